fetch_stage: RTL and testbench

Instruction-fetch stage of the pipeline. It owns the program counter and drives it as a word index into the combinational instruction code memory. It takes the returned instruction word and registers it, with its PC, into the IF/ID pipeline register feeding decode. It handles stall, flush, taken-branch redirect and halt on the all-ones sentinel word.

---
 rtl/fetch_stage_pkg.sv | 21 ++
 rtl/fetch_pc_gen.sv | 50 +++++
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: encodings, FSM states, IF/ID payload.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_WORD          = 32'h0000_0000;
    localparam logic [XLEN-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus1;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter: next-PC priority mux, modulo increment and the PC register itself.
module fetch_pc_gen
    import fetch_stage_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned AW        = 8,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  fetch_state_e state,
    input  logic         br_taken,
    input  logic         halt_seen,
    input  logic         stall,
    input  logic [AW-1:0] br_target,
    output logic [AW-1:0] pc
);

    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;
    logic [AW-1:0] pc_inc;

    assign pc_inc = AW'((XLEN'(pc_q) + XLEN'(1)) % XLEN'(MEM_DEPTH));

    // Next PC: branch beats halt beats stall beats sequential fetch; HALT freezes PC.
    always_comb begin
        pc_d = pc_q;
        if (state == FETCH_RUN) begin
            if (br_taken) begin
                pc_d = br_target;
            end else if (halt_seen || stall) begin
                pc_d = pc_q;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= AW'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, IF/ID pipeline register, halt FSM and issue counter.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned AW        = 8,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc,
    input  logic [31:0] instr_in,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus1,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_e  state_q;
    fetch_state_e  state_d;
    if_id_t        if_id_q;
    if_id_t        if_id_d;
    logic [31:0]   count_q;
    logic [31:0]   count_d;
    logic [AW-1:0] pc_idx;
    logic [AW-1:0] pc_idx_inc;
    logic          halt_seen;
    logic          unused_br_hi;

    // Target bits above the code-memory index are don't-care.
    assign unused_br_hi = ^br_target[31:AW];

    assign halt_seen  = (instr_in == HALT_WORD);
    assign pc_idx_inc = AW'((XLEN'(pc_idx) + XLEN'(1)) % XLEN'(MEM_DEPTH));

    fetch_pc_gen #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW),
        .RESET_PC  (RESET_PC)
    ) u_pc_gen (
        .clk       (clk),
        .rst       (rst),
        .state     (state_q),
        .br_taken  (br_taken),
        .halt_seen (halt_seen),
        .stall     (stall),
        .br_target (br_target[AW-1:0]),
        .pc        (pc_idx)
    );

    // Halt FSM next state and IF/ID / counter next values.
    always_comb begin
        state_d = state_q;
        if_id_d = if_id_q;
        count_d = count_q;
        if (state_q == FETCH_RUN) begin
            // A word fetched under a taken branch is wrong-path, so it cannot halt.
            if (halt_seen && !br_taken) begin
                state_d = FETCH_HALT;
            end
            if (br_taken || flush || halt_seen) begin
                if_id_d.instr = NOP_WORD;
                if_id_d.valid = 1'b0;
            end else if (!stall) begin
                if_id_d.instr    = instr_in;
                if_id_d.pc       = XLEN'(pc_idx);
                if_id_d.pc_plus1 = XLEN'(pc_idx_inc);
                if_id_d.valid    = 1'b1;
                count_d          = count_q + 32'd1;
            end
        end else begin
            if_id_d.instr = NOP_WORD;
            if_id_d.valid = 1'b0;
        end
    end

    // State, IF/ID and issue-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_RUN;
            if_id_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if_id_q <= if_id_d;
            count_q <= count_d;
        end
    end

    assign pc             = XLEN'(pc_idx);
    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc       = if_id_q.pc;
    assign if_id_pc_plus1 = if_id_q.pc_plus1;
    assign if_id_valid    = if_id_q.valid;
    assign halted         = (state_q == FETCH_HALT);
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences, randomized run vs model.
module tb_fetch_stage;

    localparam int unsigned DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] instr_in;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int unsigned m_pc;
    logic [31:0] m_instr, m_ifpc, m_p1, m_cnt;
    logic        m_valid, m_halted;

    typedef struct {
        logic        s, f, b;
        logic [31:0] t;
        logic [31:0] pc, ifpc, p1, instr;
        logic        v, h;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs [13];

    always #5 clk = ~clk;

    // Combinational code memory
    assign instr_in = mem[pc[7:0]];

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .instr_in       (instr_in),
        .stall          (stall),
        .flush          (flush),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    function automatic vec_t mk(input logic s, input logic f, input logic b, input logic [31:0] t,
                                input logic [31:0] p, input logic [31:0] ip, input logic [31:0] p1,
                                input logic [31:0] ins, input logic v, input logic h,
                                input logic [31:0] c);
        vec_t r;
        r.s = s; r.f = f; r.b = b; r.t = t;
        r.pc = p; r.ifpc = ip; r.p1 = p1; r.instr = ins;
        r.v = v; r.h = h; r.cnt = c;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " pc"},       pc,                32'(m_pc));
        check({tag, " instr"},    if_id_instr,       m_instr);
        check({tag, " if_pc"},    if_id_pc,          m_ifpc);
        check({tag, " if_pc+1"},  if_id_pc_plus1,    m_p1);
        check({tag, " valid"},    32'(if_id_valid),  32'(m_valid));
        check({tag, " halted"},   32'(halted),       32'(m_halted));
        check({tag, " count"},    fetch_count,       m_cnt);
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_ifpc = 0; m_p1 = 0;
        m_valid = 1'b0; m_halted = 1'b0; m_cnt = 0;
    endtask

    // One clock of fetch behaviour, straight from the priority rules
    task automatic model_step(input logic s, input logic f, input logic b, input logic [31:0] t);
        logic [31:0] w;
        logic        hw;
        if (m_halted) return;
        w  = mem[m_pc[7:0]];
        hw = (w == 32'hFFFF_FFFF);
        if (b || f || hw) begin
            m_instr = 0;
            m_valid = 1'b0;
        end else if (!s) begin
            m_instr = w;
            m_ifpc  = m_pc;
            m_p1    = (m_pc + 1) % DEPTH;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 1;
        end
        if (b)       m_pc = t % DEPTH;
        else if (hw) m_halted = 1'b1;
        else if (!s) m_pc = (m_pc + 1) % DEPTH;
    endtask

    task automatic step(input logic s, input logic f, input logic b, input logic [31:0] t,
                        input string tag);
        stall = s; flush = f; br_taken = b; br_target = t;
        model_step(s, f, b, t);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    // Assert reset away from a clock edge and check that outputs clear without waiting for one
    task automatic do_reset(input string tag);
        rst = 1'b1;
        stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 32'd0;
        #2;
        model_reset();
        check_model({tag, " async"});
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic fill_directed();
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = 32'h4420_0001;
        mem[1] = 32'h4440_0002;
        mem[2] = 32'h4460_0003;
        mem[7] = 32'hFFFF_FFFF;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++)
            mem[i] = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 32'd0;
        fill_directed();

        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'd0,          32'd1,  32'd0,  32'd1,  32'h4420_0001, 1'b1, 1'b0, 32'd1);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'd0,          32'd2,  32'd1,  32'd2,  32'h4440_0002, 1'b1, 1'b0, 32'd2);
        vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'd0,          32'd3,  32'd2,  32'd3,  32'h4460_0003, 1'b1, 1'b0, 32'd3);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 32'd0,          32'd3,  32'd2,  32'd3,  32'h4460_0003, 1'b1, 1'b0, 32'd3);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 32'd0,          32'd3,  32'd2,  32'd3,  32'h4460_0003, 1'b1, 1'b0, 32'd3);
        vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'd0,          32'd4,  32'd3,  32'd4,  32'h1000_0003, 1'b1, 1'b0, 32'd4);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 32'd0,          32'd5,  32'd4,  32'd5,  32'h1000_0004, 1'b1, 1'b0, 32'd5);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 32'd10,         32'd10, 32'd4,  32'd5,  32'h0,         1'b0, 1'b0, 32'd5);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'd0,          32'd11, 32'd10, 32'd11, 32'h1000_000A, 1'b1, 1'b0, 32'd6);
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 32'h1234_5607,  32'd7,  32'd10, 32'd11, 32'h0,         1'b0, 1'b0, 32'd6);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 32'd0,          32'd7,  32'd10, 32'd11, 32'h0,         1'b0, 1'b1, 32'd6);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 32'd20,         32'd7,  32'd10, 32'd11, 32'h0,         1'b0, 1'b1, 32'd6);
        vecs[12] = mk(1'b1, 1'b1, 1'b0, 32'd0,          32'd7,  32'd10, 32'd11, 32'h0,         1'b0, 1'b1, 32'd6);

        #3;
        do_reset("reset0");

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].s, vecs[i].f, vecs[i].b, vecs[i].t, $sformatf("vec%0d model", i));
            check($sformatf("vec%0d pc", i),     pc,                 vecs[i].pc);
            check($sformatf("vec%0d if_pc", i),  if_id_pc,           vecs[i].ifpc);
            check($sformatf("vec%0d if_p1", i),  if_id_pc_plus1,     vecs[i].p1);
            check($sformatf("vec%0d instr", i),  if_id_instr,        vecs[i].instr);
            check($sformatf("vec%0d valid", i),  32'(if_id_valid),   32'(vecs[i].v));
            check($sformatf("vec%0d halted", i), 32'(halted),        32'(vecs[i].h));
            check($sformatf("vec%0d count", i),  fetch_count,        vecs[i].cnt);
        end

        // Reset while halted, in the middle of a clock period
        #2;
        do_reset("rst_in_halt");
        check("rst_in_halt pc", pc, 32'd0);
        check("rst_in_halt halted", 32'(halted), 32'd0);

        // First edge after reset captures the word at address 0
        step(1'b0, 1'b0, 1'b0, 32'd0, "post_rst");
        check("post_rst instr", if_id_instr, 32'h4420_0001);

        // Branch while the halt word is on instr_in: branch wins, no halt
        step(1'b0, 1'b0, 1'b1, 32'd7, "br_to7");
        step(1'b0, 1'b0, 1'b1, 32'd30, "br_over_halt");
        check("br_over_halt pc", pc, 32'd30);
        check("br_over_halt halted", 32'(halted), 32'd0);

        // flush together with stall: bubble and PC held
        step(1'b1, 1'b1, 1'b0, 32'd0, "flush_stall");
        check("flush_stall pc", pc, 32'd30);
        check("flush_stall valid", 32'(if_id_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0, "after_fs");
        check("after_fs if_pc", if_id_pc, 32'd30);

        // Flush alone still lets the PC advance
        step(1'b0, 1'b1, 1'b0, 32'd0, "flush_only");
        check("flush_only pc", pc, 32'd32);

        // PC wrap at the top of code memory
        step(1'b0, 1'b0, 1'b1, 32'd254, "br_254");
        step(1'b0, 1'b0, 1'b0, 32'd0, "wrap0");
        check("wrap0 pc", pc, 32'd255);
        step(1'b0, 1'b0, 1'b0, 32'd0, "wrap1");
        check("wrap1 pc", pc, 32'd0);
        check("wrap1 if_pc", if_id_pc, 32'd255);
        check("wrap1 if_p1", if_id_pc_plus1, 32'd0);

        // Randomized run against the model
        fill_random();
        #2;
        do_reset("rand_rst");
        for (int c = 0; c < 600; c++) begin
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0) begin
                fill_random();
                #2;
                do_reset($sformatf("rand%0d rst", c));
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 9) == 0, 32'($urandom), $sformatf("rand%0d", c));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
